// File: rtl/screen_scan.sv
// ---------------------------------------------------------------------------
// screen_scan
//
// Purpose:
//    Raster-order pixel sweeper for the 160x120 framebuffer. After a start
//    request it presents every pixel once, left to right and top to bottom,
//    with a write enable, a fill colour latched at start, and the signed
//    world coordinate of that pixel (x_world = x - 80, y_world = 60 - y).
//    It is used to clear or fill the frame before objects are drawn, and
//    for any per-pixel world-space evaluation. The outputs drive the VGA
//    adapter write port.
//
// Ports:
//    clock      in   system clock, rising edge
//    resetn     in   synchronous active-low reset
//    start      in   begin a sweep (only looked at while idle)
//    colour_in  in   fill colour, captured when start is accepted
//    hold       in   consumer stall, current pixel is kept while high
//    x, y       out  screen coordinate of the presented pixel
//    x_world    out  signed world x of the presented pixel
//    y_world    out  signed world y of the presented pixel
//    colour     out  latched fill colour
//    writeEn    out  presented pixel is valid
//    busy       out  sweep in progress
//    done       out  single-cycle pulse after the last pixel is consumed
// ---------------------------------------------------------------------------
module screen_scan #(
   parameter int INPUT_SIZE = 9,
   parameter int HORIZONTAL = 8,
   parameter int VERTICAL   = 7,
   parameter int SCREEN_W   = 160,
   parameter int SCREEN_H   = 120,
   parameter int X_OFFSET   = 80,
   parameter int Y_OFFSET   = 60,
   parameter int COLOUR_W   = 3
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [COLOUR_W-1:0]   colour_in,
   input  logic                  hold,
   output logic [HORIZONTAL:0]   x,
   output logic [VERTICAL:0]     y,
   output logic [INPUT_SIZE:0]   x_world,
   output logic [INPUT_SIZE:0]   y_world,
   output logic [COLOUR_W-1:0]   colour,
   output logic                  writeEn,
   output logic                  busy,
   output logic                  done
);

   localparam int XW = HORIZONTAL + 1;
   localparam int YW = VERTICAL + 1;
   localparam int WW = INPUT_SIZE + 1;

   localparam logic [HORIZONTAL:0] X_LAST = XW'(SCREEN_W - 1);
   localparam logic [VERTICAL:0]   Y_LAST = YW'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [HORIZONTAL:0]   x_q, x_d;
   logic [VERTICAL:0]     y_q, y_d;
   logic [COLOUR_W-1:0]   colour_q, colour_d;

   // State, position and colour registers. Reset wins over every other
   // input, so a sweep in flight is simply dropped without a done pulse.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
      end
   end

   // Next-state logic. A pixel advances only on a cycle where hold is low;
   // the end of a row wraps x and bumps y, and consuming the bottom-right
   // pixel leaves x/y parked there while the done cycle is shown.
   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               colour_d = colour_in;
               x_d      = '0;
               y_d      = '0;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            if (!hold) begin
               if (x_q == X_LAST) begin
                  if (y_q == Y_LAST) begin
                     state_d = DONE;
                  end else begin
                     x_d = '0;
                     y_d = y_q + YW'(1);
                  end
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs depend only on registered state, so start/hold never reach
   // them combinationally.
   assign writeEn = (state_q == SCAN);
   assign busy    = (state_q == SCAN);
   assign done    = (state_q == DONE);
   assign x       = x_q;
   assign y       = y_q;
   assign colour  = colour_q;

   // World mapping: zero-extend the screen coordinate and let the
   // two's-complement subtraction wrap at the world width.
   assign x_world = WW'(x_q) - WW'(X_OFFSET);
   assign y_world = WW'(Y_OFFSET) - WW'(y_q);

endmodule

// File: tb/tb_screen_scan.sv
// ---------------------------------------------------------------------------
// tb_screen_scan
//
// Self-checking bench for screen_scan: a table of short directed vectors,
// then full sweeps with hand-placed corner events and random hold, each
// cycle compared with a pixel-index reference model.
// ---------------------------------------------------------------------------
module tb_screen_scan;

   localparam int NPIX = 160 * 120;

   logic          clock;
   logic          resetn;
   logic          start;
   logic [2:0]    colour_in;
   logic          hold;
   logic [8:0]    x;
   logic [7:0]    y;
   logic [9:0]    x_world;
   logic [9:0]    y_world;
   logic [2:0]    colour;
   logic          writeEn;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   // Reference model: mode 0=idle 1=scanning 2=done, pixel as a linear index.
   int mMode = 0;
   int mPix  = 0;
   int mCol  = 0;

   screen_scan dut (
      .clock     (clock),
      .resetn    (resetn),
      .start     (start),
      .colour_in (colour_in),
      .hold      (hold),
      .x         (x),
      .y         (y),
      .x_world   (x_world),
      .y_world   (y_world),
      .colour    (colour),
      .writeEn   (writeEn),
      .busy      (busy),
      .done      (done)
   );

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one cycle of inputs, let the rising edge happen, then advance
   // the reference model with the same inputs. Outputs settle by #1.
   task automatic applyStimulus(input bit rn, input bit st, input logic [2:0] co, input bit hd);
      resetn    = rn;
      start     = st;
      colour_in = co;
      hold      = hd;
      @(posedge clock);
      #1;
      if (!rn) begin
         mMode = 0;
         mPix  = 0;
         mCol  = 0;
      end else begin
         case (mMode)
            0: if (st) begin
                  mMode = 1;
                  mPix  = 0;
                  mCol  = int'(co);
               end
            1: if (!hd) begin
                  if (mPix == NPIX - 1) mMode = 2;
                  else mPix = mPix + 1;
               end
            default: mMode = 0;
         endcase
      end
   endtask

   // Compare every output against the reference model.
   task automatic checkOutput(input string nm);
      int ex, ey;
      bit ok;
      ex = mPix % 160;
      ey = mPix / 160;
      ok = (writeEn === (mMode == 1)) && (busy === (mMode == 1)) &&
           (done === (mMode == 2)) && (x === 9'(ex)) && (y === 8'(ey)) &&
           (int'($signed(x_world)) == ex - 80) && (int'($signed(y_world)) == 60 - ey) &&
           (colour === 3'(mCol)) && !$isunknown({x_world, y_world});
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s: got we=%b busy=%b done=%b x=%0d y=%0d xw=%0d yw=%0d col=%0d, expected we=%0b busy=%0b done=%0b x=%0d y=%0d xw=%0d yw=%0d col=%0d",
                  nm, writeEn, busy, done, x, y, $signed(x_world), $signed(y_world), colour,
                  mMode == 1, mMode == 1, mMode == 2, ex, ey, ex - 80, 60 - ey, mCol);
      end
   endtask

   task automatic checkVal(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      bit         rn;
      bit         st;
      logic [2:0] co;
      bit         hd;
      bit         we;
      bit         bs;
      bit         dn;
      int         ex;
      int         ey;
      int         exw;
      int         eyw;
      int         ecol;
   } vec_t;

   typedef struct {
      int px;
      int py;
      int xw;
      int yw;
   } corner_t;

   vec_t    vecs[9];
   corner_t corners[5];

   initial begin
      int weCnt, doneCnt, doneAt, holdCnt, stuckCnt, forcedLeft;
      bit hd, st;

      resetn    = 1'b0;
      start     = 1'b0;
      colour_in = 3'd0;
      hold      = 1'b0;

      // Directed vectors: reset, reset-over-start, start with hold, a few
      // pixels, ignored start, and reset mid-sweep.
      vecs[0] = '{0, 0, 3'd0, 0, 0, 0, 0, 0, 0, -80, 60, 0};
      vecs[1] = '{0, 1, 3'd7, 0, 0, 0, 0, 0, 0, -80, 60, 0};
      vecs[2] = '{1, 0, 3'd0, 0, 0, 0, 0, 0, 0, -80, 60, 0};
      vecs[3] = '{1, 1, 3'd3, 1, 1, 1, 0, 0, 0, -80, 60, 3};
      vecs[4] = '{1, 0, 3'd0, 1, 1, 1, 0, 0, 0, -80, 60, 3};
      vecs[5] = '{1, 0, 3'd0, 0, 1, 1, 0, 1, 0, -79, 60, 3};
      vecs[6] = '{1, 1, 3'd6, 0, 1, 1, 0, 2, 0, -78, 60, 3};
      vecs[7] = '{0, 0, 3'd0, 0, 0, 0, 0, 0, 0, -80, 60, 0};
      vecs[8] = '{1, 0, 3'd0, 0, 0, 0, 0, 0, 0, -80, 60, 0};

      corners[0] = '{0,   0,   -80, 60};
      corners[1] = '{159, 0,    79, 60};
      corners[2] = '{0,   119, -80, -59};
      corners[3] = '{159, 119,  79, -59};
      corners[4] = '{80,  60,    0, 0};

      for (int i = 0; i < 9; i++) begin
         bit ok;
         applyStimulus(vecs[i].rn, vecs[i].st, vecs[i].co, vecs[i].hd);
         ok = (writeEn === vecs[i].we) && (busy === vecs[i].bs) && (done === vecs[i].dn) &&
              (x === 9'(vecs[i].ex)) && (y === 8'(vecs[i].ey)) &&
              (x_world === 10'(vecs[i].exw)) && (y_world === 10'(vecs[i].eyw)) &&
              (colour === 3'(vecs[i].ecol));
         total++;
         if (!ok) begin
            bad++;
            $display("[TB] FAIL vec%0d: got we=%b busy=%b done=%b x=%0d y=%0d xw=%h yw=%h col=%0d, expected we=%0b busy=%0b done=%0b x=%0d y=%0d xw=%0d yw=%0d col=%0d",
                     i, writeEn, busy, done, x, y, x_world, y_world, colour,
                     vecs[i].we, vecs[i].bs, vecs[i].dn, vecs[i].ex, vecs[i].ey,
                     vecs[i].exw, vecs[i].eyw, vecs[i].ecol);
         end
      end

      // Full sweep without hold, colour 5, with an ignored start at (10,2).
      weCnt = 0; doneCnt = 0; doneAt = -1;
      applyStimulus(1, 1, 3'b101, 0);
      checkOutput("sweepA_start");
      for (int c = 1; c <= NPIX + 10; c++) begin
         if (writeEn) weCnt++;
         if (done) begin
            doneCnt++;
            doneAt = c;
         end
         for (int k = 0; k < 5; k++) begin
            if (writeEn && mMode == 1 && mPix == corners[k].py * 160 + corners[k].px) begin
               checkVal("cornerXw", int'($signed(x_world)), corners[k].xw);
               checkVal("cornerYw", int'($signed(y_world)), corners[k].yw);
            end
         end
         st = (mMode == 1 && mPix == 2 * 160 + 10);
         applyStimulus(1, st, st ? 3'b010 : 3'b000, 0);
         checkOutput("sweepA");
      end
      checkVal("sweepA_weCount", weCnt, NPIX);
      checkVal("sweepA_doneCount", doneCnt, 1);
      checkVal("sweepA_doneCycle", doneAt, NPIX + 1);

      // Sweep with random hold plus three forced hold cycles at (159,5).
      weCnt = 0; doneCnt = 0; doneAt = -1; holdCnt = 0; stuckCnt = 0; forcedLeft = 3;
      applyStimulus(1, 1, 3'($urandom_range(0, 7)), 0);
      checkOutput("sweepB_start");
      for (int c = 1; c <= 30000 && doneAt < 0; c++) begin
         if (writeEn) weCnt++;
         if (writeEn && x == 9'd159 && y == 8'd5) stuckCnt++;
         if (done) begin
            doneCnt++;
            doneAt = c;
         end
         if (mMode == 1 && mPix == 5 * 160 + 159) begin
            hd = (forcedLeft > 0);
            if (forcedLeft > 0) forcedLeft--;
         end else begin
            hd = ($urandom_range(0, 7) == 0);
         end
         if (hd && mMode == 1) holdCnt++;
         applyStimulus(1, $urandom_range(0, 15) == 0, 3'($urandom_range(0, 7)), hd);
         checkOutput("sweepB");
      end
      checkVal("sweepB_rowWrapHold", stuckCnt, 4);
      checkVal("sweepB_weCycles", weCnt, NPIX + holdCnt);
      checkVal("sweepB_doneCycle", doneAt, NPIX + 1 + holdCnt);
      applyStimulus(1, 0, 3'd0, 0);
      checkOutput("sweepB_idle");

      // Reset in the middle of a sweep at (40,30), then restart.
      applyStimulus(1, 1, 3'b110, 0);
      for (int c = 0; c < 6000 && !(mMode == 1 && mPix == 30 * 160 + 40); c++) begin
         applyStimulus(1, 0, 3'd0, 0);
      end
      checkVal("midReset_reached", (x == 9'd40 && y == 8'd30 && writeEn) ? 1 : 0, 1);
      applyStimulus(0, 0, 3'd0, 0);
      checkOutput("midReset");
      doneCnt = 0;
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1, 0, 3'd0, 0);
         if (done) doneCnt++;
         checkOutput("midReset_idle");
      end
      checkVal("midReset_noDone", doneCnt, 0);
      applyStimulus(1, 1, 3'b011, 0);
      checkOutput("restart_first");
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, 0, 3'd0, 0);
         checkOutput("restart");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
